core_dp_mc: RTL and testbench
=============================

Name: core_dp_mc

Overview:
- Parametrised multicycle CPU datapath: register file, PC, IR, MAR, MDR, ALU with registered flags, and an internal memory-access FSM.
- Replaces direct memory instantiation with a req/ready memory port, so a controller FSM can drive it against memories of any latency.
- Sits between the core controller (control inputs) and the memory subsystem.

Parameters:
- XLEN, 32, datapath and register width.
- NREGS, 32, register count (power of 2, ≥2); index width RW = clog2(NREGS).
- AW, 16, memory byte-address width (AW ≤ XLEN); PC and MAR are AW bits.
- PC_STEP, 4, PC increment.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- pc_inc_i  in  1  PC += PC_STEP.
- pc_load_i  in  1  PC ← alu_result[AW-1:0].
- ir_we_i  in  1  IR ← MDR.
- mar_load_i  in  1  load MAR.
- mar_sel_i  in  1  0: PC, 1: alu_result[AW-1:0].
- rf_we_i  in  1  write rd.
- rf_wsel_i  in  1  0: alu_result, 1: MDR.
- alu_a_sel_i  in  1  0: rs1 data, 1: PC zero-extended.
- alu_b_sel_i  in  1  0: rs2 data, 1: imm_i.
- alu_op_i  in  3  ALU operation.
- flag_we_i  in  1  register ALU flags.
- rs1_i, rs2_i, rd_i  in  RW each  register indices.
- imm_i  in  XLEN  immediate.
- mem_start_i  in  1  start a memory access.
- mem_write_i  in  1  access type at start: 1 write, 0 read.
- mem_req_o  out  1  request valid.
- mem_we_o  out  1  write strobe (qualified by req).
- mem_addr_o  out  AW  = MAR.
- mem_wdata_o  out  XLEN  write data latched at start.
- mem_rdata_i  in  XLEN  read data, valid with ready.
- mem_ready_i  in  1  memory completes the request.
- mem_busy_o  out  1  FSM not IDLE.
- mem_done_o  out  1  one-cycle completion pulse.
- alu_flags_o  out  3  {C, N, Z} registered.
- pc_o  out  AW  PC.
- ir_o  out  XLEN  IR.

Behaviour:
- Reset (async, immediate): PC, IR, MAR, MDR, wdata, flags = 0; FSM = IDLE; mem_req_o = mem_we_o = mem_done_o = 0. Register file contents are not reset, except r0.
- Register file: r0 reads 0 and ignores writes. Two asynchronous read ports, one synchronous write port. Reading the register being written in the same cycle returns the old value; there is no bypass.
- PC: pc_load_i has priority over pc_inc_i. Arithmetic is modulo 2^AW, e.g. PC = 2^AW−4 with inc gives 0.
- ALU is combinational. PC and MAR operands are zero-extended to XLEN.
  - 000 add, 001 sub, 010 and, 011 or, 100 xor.
  - 101 sll by b[clog2(XLEN)-1:0]; 110 srl by the same amount, logical.
  - 111 slt, signed: result 1 or 0.
  - Z = (result == 0). N = result[XLEN-1].
  - C = carry-out for add. For sub, C = borrow (a < b unsigned). C = 0 for all other ops.
  - Flags update only on flag_we_i.
- Memory FSM, states IDLE, REQ, DONE:
  - IDLE: on mem_start_i, latch mem_write_i and rs2 data into wdata, then go to REQ.
  - REQ: mem_req_o = 1 and mem_we_o = latched type. Hold until mem_ready_i is sampled high. On the ready edge of a read, MDR ← mem_rdata_i. Then go to DONE.
  - DONE: mem_done_o = 1 for exactly one cycle, then go to IDLE.
  - mem_busy_o = (state ≠ IDLE). All memory outputs are registered or direct state decode; no combinational path from mem_ready_i.
- Latency: start at edge t → req high from t+1. Ready sampled at edge t+k → done high during cycle t+k+1; MDR valid from that cycle. Zero-wait memory (ready already high) gives done 2 cycles after start.
- Boundary rules:
  - mem_start_i while busy (including DONE) is ignored.
  - mar_load_i during REQ is ignored, so the address stays stable while requested.
  - mem_ready_i in IDLE or DONE is ignored.
  - MDR is unchanged on a write.
  - rf, PC, IR and flags may update during REQ.
  - rst_i during REQ drops mem_req_o at once; no done pulse follows.
  - rf_we_i with rd_i = 0 has no effect.

Test Plan:
1. Reset mid-access: start a read, hold ready low 3 cycles, assert rst_i → req falls the same cycle, busy = 0, PC = 0, no done pulse.
2. ALU/flags: rs1 = 0xFFFFFFFF, imm = 1, op add, flag_we → rd = 0, flags C = 1, N = 0, Z = 1. Sub 3 − 5 → 0xFFFFFFFE, C = 1, N = 1. Slt −1 vs 1 → 1.
3. Read with 3 wait states: MAR = 0x0010, start read, ready on the 4th REQ cycle with rdata 0xDEADBEEF → done pulses once, the MDR write to r5 reads back 0xDEADBEEF, addr is stable at 0x0010 despite mar_load during REQ.
4. Zero-wait write: r2 = 0x12345678, start write with ready tied high → one-cycle req with we = 1, wdata 0x12345678, done 2 cycles after start. A start pulse during DONE is ignored.
5. PC: load 0xFFFC, then inc → 0x0000. Load and inc in the same cycle → load value wins.
6. r0 protection and no bypass: write 0xAA to r0 → reads 0. Write r3 = 7 while reading r3 in the same cycle → old value, then 7 on the next cycle.

Source files
------------

// File: rtl/core_dp_mc.sv
// Multicycle CPU datapath: register file, PC/IR/MAR/MDR, ALU with registered flags,
// and a req/ready memory-access sequencer so memories of any latency can be used.
module core_dp_mc #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int AW      = 16,
  parameter int PC_STEP = 4,
  localparam int RW     = $clog2(NREGS)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            pc_inc_i,
  input  logic            pc_load_i,
  input  logic            ir_we_i,
  input  logic            mar_load_i,
  input  logic            mar_sel_i,
  input  logic            rf_we_i,
  input  logic            rf_wsel_i,
  input  logic            alu_a_sel_i,
  input  logic            alu_b_sel_i,
  input  logic [2:0]      alu_op_i,
  input  logic            flag_we_i,
  input  logic [RW-1:0]   rs1_i,
  input  logic [RW-1:0]   rs2_i,
  input  logic [RW-1:0]   rd_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic            mem_start_i,
  input  logic            mem_write_i,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic [XLEN-1:0] mem_rdata_i,
  input  logic            mem_ready_i,
  output logic            mem_busy_o,
  output logic            mem_done_o,
  output logic [2:0]      alu_flags_o,
  output logic [AW-1:0]   pc_o,
  output logic [XLEN-1:0] ir_o
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, REQ, DONE} mem_state_e;
  mem_state_e state_q;
  logic       we_q;

  logic [XLEN-1:0] rf_q [NREGS];
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic [AW-1:0]   pc_q, pc_d, mar_q, mar_d;
  logic [XLEN-1:0] ir_q, ir_d, mdr_q, mdr_d, wdata_q, wdata_d;
  logic [2:0]      flags_q, flags_d;
  logic [XLEN-1:0] alu_a, alu_b, alu_res;
  logic [XLEN:0]   sum_w;
  logic            alu_c;

  // r0 is hardwired to zero on the read side; writes to it are dropped below
  assign rs1_data = (rs1_i == '0) ? '0 : rf_q[rs1_i];
  assign rs2_data = (rs2_i == '0) ? '0 : rf_q[rs2_i];

  always_ff @(posedge clk_i) begin
    if (rf_we_i && rd_i != '0) rf_q[rd_i] <= rf_wsel_i ? mdr_q : alu_res;
  end

  always_comb begin
    alu_a   = alu_a_sel_i ? XLEN'(pc_q) : rs1_data;
    alu_b   = alu_b_sel_i ? imm_i : rs2_data;
    sum_w   = {1'b0, alu_a} + {1'b0, alu_b};
    alu_res = '0;
    alu_c   = 1'b0;
    case (alu_op_i)
      3'b000: begin alu_res = sum_w[XLEN-1:0]; alu_c = sum_w[XLEN]; end
      3'b001: begin alu_res = alu_a - alu_b;   alu_c = (alu_a < alu_b); end
      3'b010: alu_res = alu_a & alu_b;
      3'b011: alu_res = alu_a | alu_b;
      3'b100: alu_res = alu_a ^ alu_b;
      3'b101: alu_res = alu_a << alu_b[SHW-1:0];
      3'b110: alu_res = alu_a >> alu_b[SHW-1:0];
      default: alu_res = {{(XLEN-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (pc_load_i)     pc_d = alu_res[AW-1:0];
    else if (pc_inc_i) pc_d = pc_q + AW'(PC_STEP);
    ir_d  = ir_we_i ? mdr_q : ir_q;
    // address is frozen while a request is outstanding
    mar_d = mar_q;
    if (mar_load_i && state_q != REQ) mar_d = mar_sel_i ? alu_res[AW-1:0] : pc_q;
    flags_d = flag_we_i ? {alu_c, alu_res[XLEN-1], (alu_res == '0)} : flags_q;
    mdr_d   = (state_q == REQ && mem_ready_i && !we_q) ? mem_rdata_i : mdr_q;
    wdata_d = (state_q == IDLE && mem_start_i) ? rs2_data : wdata_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q    <= '0;
      ir_q    <= '0;
      mar_q   <= '0;
      mdr_q   <= '0;
      wdata_q <= '0;
      flags_q <= '0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      wdata_q <= wdata_d;
      flags_q <= flags_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (mem_start_i) begin
          state_q <= REQ;
          we_q    <= mem_write_i;
        end
        REQ:     if (mem_ready_i) state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // outputs are pure state decode, so nothing combinational from mem_ready_i
  assign mem_req_o   = (state_q == REQ);
  assign mem_we_o    = mem_req_o & we_q;
  assign mem_done_o  = (state_q == DONE);
  assign mem_busy_o  = (state_q != IDLE);
  assign mem_addr_o  = mar_q;
  assign mem_wdata_o = wdata_q;
  assign alu_flags_o = flags_q;
  assign pc_o        = pc_q;
  assign ir_o        = ir_q;
endmodule

// File: tb/tb_core_dp_mc.sv
// Bench for core_dp_mc: directed sequences, a cycle-level reference model with a
// per-cycle output compare, and literal expectations for the key scenarios.
module tb_core_dp_mc;
  localparam int XLEN = 32, NREGS = 32, AW = 16, RW = 5;

  logic clk = 1'b0, rst = 1'b0;
  logic pc_inc, pc_load, ir_we, mar_load, mar_sel, rf_we, rf_wsel;
  logic alu_a_sel, alu_b_sel, flag_we, mem_start, mem_write, mem_ready;
  logic [2:0] alu_op;
  logic [RW-1:0] rs1, rs2, rd;
  logic [XLEN-1:0] imm, mem_rdata;
  logic mem_req, mem_we, mem_busy, mem_done;
  logic [AW-1:0] mem_addr, pc;
  logic [XLEN-1:0] mem_wdata, ir;
  logic [2:0] flags;

  int n_tests = 0, n_fail = 0, done_cnt = 0;

  core_dp_mc #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .PC_STEP(4)) dut (
    .clk_i(clk), .rst_i(rst), .pc_inc_i(pc_inc), .pc_load_i(pc_load), .ir_we_i(ir_we),
    .mar_load_i(mar_load), .mar_sel_i(mar_sel), .rf_we_i(rf_we), .rf_wsel_i(rf_wsel),
    .alu_a_sel_i(alu_a_sel), .alu_b_sel_i(alu_b_sel), .alu_op_i(alu_op), .flag_we_i(flag_we),
    .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .imm_i(imm), .mem_start_i(mem_start),
    .mem_write_i(mem_write), .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready),
    .mem_busy_o(mem_busy), .mem_done_o(mem_done), .alu_flags_o(flags), .pc_o(pc), .ir_o(ir)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_rf [NREGS];
  logic [15:0] m_pc, m_mar;
  logic [31:0] m_ir, m_mdr, m_wd, ma, mb, mres, old_mdr;
  logic [2:0]  m_fl, mfl;
  bit m_req, m_we, m_done;

  function automatic logic [31:0] rf_rd(input logic [RW-1:0] i);
    return (i == 0) ? 32'h0 : m_rf[i];
  endfunction

  function automatic void model_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [2:0] f);
    logic [63:0] s;
    logic c;
    c = 1'b0;
    s = {32'h0, a} + {32'h0, b};
    case (op)
      3'd0: begin r = s[31:0]; c = s[32]; end
      3'd1: begin r = a - b; c = (a < b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << (b % 32);
      3'd6: r = a >> (b % 32);
      default: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
    f = {c, r[31], (r == 32'h0)};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = '0; m_ir = '0; m_mar = '0; m_mdr = '0; m_wd = '0; m_fl = '0;
      m_req = 0; m_we = 0; m_done = 0;
    end else begin
      ma = alu_a_sel ? {16'h0, m_pc} : rf_rd(rs1);
      mb = alu_b_sel ? imm : rf_rd(rs2);
      model_alu(alu_op, ma, mb, mres, mfl);
      old_mdr = m_mdr;
      if (mar_load && !m_req) m_mar = mar_sel ? mres[15:0] : m_pc;
      if (pc_load) m_pc = mres[15:0];
      else if (pc_inc) m_pc = m_pc + 16'd4;
      if (flag_we) m_fl = mfl;
      if (ir_we) m_ir = old_mdr;
      if (m_done) m_done = 0;
      else if (m_req) begin
        if (mem_ready) begin
          if (!m_we) m_mdr = mem_rdata;
          m_req = 0; m_we = 0; m_done = 1;
        end
      end else if (mem_start) begin
        m_req = 1; m_we = mem_write; m_wd = rf_rd(rs2);
      end
      if (rf_we && rd != 0) m_rf[rd] = rf_wsel ? old_mdr : mres;
    end
  end

  always @(negedge clk) begin
    chk("cyc_pc", 32'(pc), 32'(m_pc));
    chk("cyc_ir", ir, m_ir);
    chk("cyc_flags", 32'(flags), 32'(m_fl));
    chk("cyc_addr", 32'(mem_addr), 32'(m_mar));
    chk("cyc_req", 32'(mem_req), 32'(m_req));
    chk("cyc_we", 32'(mem_we), 32'(m_req & m_we));
    chk("cyc_busy", 32'(mem_busy), 32'(m_req | m_done));
    chk("cyc_done", 32'(mem_done), 32'(m_done));
    chk("cyc_wdata", mem_wdata, m_wd);
    if (mem_done === 1'b1) done_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(); @(posedge clk); #1; endtask

  task automatic clr();
    pc_inc = 0; pc_load = 0; ir_we = 0; mar_load = 0; mar_sel = 0; rf_we = 0; rf_wsel = 0;
    alu_a_sel = 0; alu_b_sel = 0; alu_op = 0; flag_we = 0; rs1 = 0; rs2 = 0; rd = 0;
    imm = 0; mem_start = 0; mem_write = 0;
  endtask

  task automatic setreg(input logic [RW-1:0] r, input logic [31:0] v);
    clr(); alu_b_sel = 1; imm = v; rf_we = 1; rd = r; step(); clr();
  endtask

  // register readback through the write-data latch of a memory write
  task automatic readreg(input logic [RW-1:0] r, output logic [31:0] v);
    clr(); mem_ready = 0; rs2 = r; mem_start = 1; mem_write = 1; step();
    clr(); v = mem_wdata; mem_ready = 1; step();
    mem_ready = 0; step();
  endtask

  task automatic alu_vec(input string name, input logic [2:0] op, input logic [31:0] i,
                         input logic [31:0] exp);
    logic [31:0] v;
    clr(); rs1 = 10; alu_b_sel = 1; imm = i; alu_op = op; rd = 11; rf_we = 1; flag_we = 1; step();
    readreg(11, v);
    chk(name, v, exp);
  endtask

  logic [31:0] v;
  int d0;

  initial begin
    clr(); mem_ready = 0; mem_rdata = 0;
    #2 rst = 1;
    step(); step();
    chk("rst_pc", 32'(pc), 0); chk("rst_ir", ir, 0); chk("rst_flags", 32'(flags), 0);
    chk("rst_req", 32'(mem_req), 0); chk("rst_done", 32'(mem_done), 0);
    rst = 0; step();

    // reset in the middle of a pending read
    pc_inc = 1; step(); step(); clr();
    chk("pc_inc2", 32'(pc), 32'h8);
    mem_start = 1; mem_write = 0; step(); clr();
    chk("t1_req", 32'(mem_req), 1);
    d0 = done_cnt;
    step(); step();
    rst = 1; #1;
    chk("t1_req_drop", 32'(mem_req), 0); chk("t1_busy", 32'(mem_busy), 0); chk("t1_pc", 32'(pc), 0);
    step(); rst = 0; step(); step(); step();
    chk("t1_no_done", done_cnt - d0, 0);

    // ALU and flags
    setreg(1, 32'hFFFF_FFFF);
    clr(); rs1 = 1; alu_b_sel = 1; imm = 1; flag_we = 1; rf_we = 1; rd = 4; step(); clr();
    chk("t2_add_flags", 32'(flags), 32'b101);
    readreg(4, v); chk("t2_add_res", v, 0);
    setreg(6, 3); setreg(7, 5);
    clr(); rs1 = 6; rs2 = 7; alu_op = 1; flag_we = 1; rf_we = 1; rd = 8; step(); clr();
    chk("t2_sub_flags", 32'(flags), 32'b110);
    readreg(8, v); chk("t2_sub_res", v, 32'hFFFF_FFFE);
    clr(); rs1 = 1; alu_b_sel = 1; imm = 1; alu_op = 7; rf_we = 1; rd = 9; step(); clr();
    readreg(9, v); chk("t2_slt", v, 1);
    setreg(10, 32'h8000_0001);
    alu_vec("t2_sll", 3'd5, 4, 32'h0000_0010);
    alu_vec("t2_sll_wrap", 3'd5, 36, 32'h0000_0010);
    alu_vec("t2_srl", 3'd6, 4, 32'h0800_0000);
    alu_vec("t2_and", 3'd2, 32'hFF, 32'h1);
    alu_vec("t2_or", 3'd3, 32'hF0, 32'h8000_00F1);
    alu_vec("t2_xor", 3'd4, 32'hFFFF_FFFF, 32'h7FFF_FFFE);
    alu_vec("t2_slt_neg", 3'd7, 0, 32'h1);

    // read with three wait states; MAR held despite loads during REQ
    clr(); mar_load = 1; mar_sel = 1; alu_b_sel = 1; imm = 32'h10; step(); clr();
    chk("t3_mar", 32'(mem_addr), 32'h10);
    d0 = done_cnt;
    mem_start = 1; mem_write = 0; step(); clr();
    mar_load = 1; mar_sel = 1; alu_b_sel = 1; imm = 32'h40;
    step(); step(); step();
    mem_ready = 1; mem_rdata = 32'hDEAD_BEEF;
    chk("t3_req4", 32'(mem_req), 1); chk("t3_addr", 32'(mem_addr), 32'h10);
    step(); clr(); mem_ready = 0; mem_rdata = 0;
    chk("t3_done", 32'(mem_done), 1);
    rf_we = 1; rf_wsel = 1; rd = 5; ir_we = 1; step(); clr();
    chk("t3_done_once", done_cnt - d0, 1); chk("t3_ir", ir, 32'hDEAD_BEEF);
    readreg(5, v); chk("t3_r5", v, 32'hDEAD_BEEF);

    // zero-wait write; start during DONE ignored; ready in IDLE ignored
    setreg(2, 32'h1234_5678);
    mem_ready = 1; step();
    chk("t4_idle_ready", 32'(mem_busy), 0);
    rs2 = 2; mem_start = 1; mem_write = 1; step(); clr();
    chk("t4_req", 32'(mem_req), 1); chk("t4_we", 32'(mem_we), 1);
    chk("t4_wdata", mem_wdata, 32'h1234_5678);
    step();
    chk("t4_done", 32'(mem_done), 1); chk("t4_req_off", 32'(mem_req), 0);
    mem_start = 1; step(); clr();
    chk("t4_ignored", 32'(mem_busy), 0); chk("t4_done_off", 32'(mem_done), 0);
    mem_ready = 0; step();

    // PC wrap and priority
    clr(); alu_b_sel = 1; imm = 32'hFFFC; pc_load = 1; step(); clr();
    chk("t5_load", 32'(pc), 32'hFFFC);
    pc_inc = 1; step(); clr();
    chk("t5_wrap", 32'(pc), 0);
    alu_b_sel = 1; imm = 32'h1234; pc_load = 1; pc_inc = 1; step(); clr();
    chk("t5_prio", 32'(pc), 32'h1234);
    alu_a_sel = 1; alu_b_sel = 1; imm = 8; pc_load = 1; step(); clr();
    chk("t5_pc_rel", 32'(pc), 32'h123C);

    // r0 protection and no write-to-read bypass
    setreg(0, 32'hAA);
    readreg(0, v); chk("t6_r0", v, 0);
    setreg(3, 5);
    clr(); alu_b_sel = 1; imm = 7; rf_we = 1; rd = 3; rs2 = 3; mem_start = 1; mem_write = 1;
    step(); clr();
    chk("t6_old", mem_wdata, 5);
    mem_ready = 1; step(); mem_ready = 0; step();
    readreg(3, v); chk("t6_new", v, 7);

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
